// File: rtl/vend_pkg.sv
// Shared types for the newspaper vending coin scheduler: coin codes, FSM states
// and coin values in cents.
package vend_pkg;

  typedef enum logic [1:0] {
    NONE    = 2'b00,
    NICKEL  = 2'b01,
    DIME    = 2'b10,
    INVALID = 2'b11
  } coin_e;

  typedef enum logic [2:0] {
    IDLE,
    C5,
    C10,
    DISPENSE,
    CHANGE,
    FAULT
  } state_e;

  localparam logic [4:0] NICKEL_CENTS = 5'd5;
  localparam logic [4:0] DIME_CENTS   = 5'd10;

  function automatic logic [4:0] coin_cents(input coin_e code);
    case (code)
      NICKEL:  return NICKEL_CENTS;
      DIME:    return DIME_CENTS;
      default: return 5'd0;
    endcase
  endfunction

  // Credit-tracking state for a balance still below the price.
  function automatic state_e credit_state(input logic [4:0] credit);
    if (credit == 5'd0) return IDLE;
    else if (credit == NICKEL_CENTS) return C5;
    else return C10;
  endfunction

endpackage

// File: rtl/vend_rr_arb.sv
// Two-requester round-robin arbiter; on a tie the slot not granted last wins.
module vend_rr_arb (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  logic last_b_q, last_b_d;

  assign gnt_a_o = en_i & req_a_i & (~req_b_i | last_b_q);
  assign gnt_b_o = en_i & req_b_i & (~req_a_i | ~last_b_q);

  always_comb begin
    last_b_d = last_b_q;
    if (gnt_b_o)      last_b_d = 1'b1;
    else if (gnt_a_o) last_b_d = 1'b0;
  end

  // "B last" out of reset so slot A wins the first tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) last_b_q <= 1'b1;
    else       last_b_q <= last_b_d;
  end

endmodule

// File: rtl/vend_coin_scheduler.sv
// Newspaper vending controller: accepts coins from two slots, dispenses at PRICE,
// returns one nickel of change and latches a fault on acknowledge timeout.
module vend_coin_scheduler
  import vend_pkg::*;
#(
  parameter int DISP_TIMEOUT = 16,
  parameter int PRICE        = 15
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] coin_a_i,
  input  logic [1:0] coin_b_i,
  output logic       ready_a_o,
  output logic       ready_b_o,
  input  logic       dispense_ack_i,
  input  logic       change_ack_i,
  output logic       newspaper_o,
  output logic       change_req_o,
  output logic [4:0] credit_o,
  output logic       coin_reject_o,
  output logic       fault_o
);

  localparam logic [4:0] PRICE_C    = 5'(PRICE);
  localparam logic [4:0] TIMER_LAST = 5'(DISP_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [4:0] credit_q, credit_d;
  logic [4:0] timer_q, timer_d;
  logic       newspaper_q, newspaper_d;
  logic       change_req_q, change_req_d;
  logic       coin_reject_q, coin_reject_d;
  logic       fault_q, fault_d;

  logic       accept_en, gnt_a, gnt_b;
  coin_e      coin_sel;
  logic [4:0] sum, remaining;

  assign accept_en = (state_q == IDLE) || (state_q == C5) || (state_q == C10);

  vend_rr_arb u_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (accept_en),
    .req_a_i (coin_a_i != NONE),
    .req_b_i (coin_b_i != NONE),
    .gnt_a_o (gnt_a),
    .gnt_b_o (gnt_b)
  );

  assign coin_sel = gnt_a ? coin_e'(coin_a_i) : coin_e'(coin_b_i);

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    timer_d       = timer_q;
    newspaper_d   = newspaper_q;
    change_req_d  = change_req_q;
    coin_reject_d = 1'b0;
    fault_d       = fault_q;
    sum           = credit_q + coin_cents(coin_sel);
    remaining     = credit_q - PRICE_C;
    case (state_q)
      IDLE, C5, C10: begin
        if (gnt_a || gnt_b) begin
          if (coin_sel == INVALID) begin
            coin_reject_d = 1'b1;
          end else begin
            credit_d = sum;
            if (sum >= PRICE_C) begin
              state_d     = DISPENSE;
              newspaper_d = 1'b1;
              timer_d     = 5'd0;
            end else begin
              state_d = credit_state(sum);
            end
          end
        end
      end
      DISPENSE: begin
        // An ack on the expiry cycle takes priority over the fault.
        if (dispense_ack_i) begin
          credit_d    = remaining;
          newspaper_d = 1'b0;
          if (remaining == NICKEL_CENTS) begin
            state_d      = CHANGE;
            change_req_d = 1'b1;
            timer_d      = 5'd0;
          end else begin
            state_d = credit_state(remaining);
          end
        end else if (timer_q == TIMER_LAST) begin
          state_d     = FAULT;
          fault_d     = 1'b1;
          newspaper_d = 1'b0;
        end else begin
          timer_d = timer_q + 5'd1;
        end
      end
      CHANGE: begin
        if (change_ack_i) begin
          credit_d     = 5'd0;
          change_req_d = 1'b0;
          state_d      = IDLE;
        end else if (timer_q == TIMER_LAST) begin
          state_d      = FAULT;
          fault_d      = 1'b1;
          change_req_d = 1'b0;
        end else begin
          timer_d = timer_q + 5'd1;
        end
      end
      FAULT:   ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      credit_q      <= 5'd0;
      timer_q       <= 5'd0;
      newspaper_q   <= 1'b0;
      change_req_q  <= 1'b0;
      coin_reject_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      timer_q       <= timer_d;
      newspaper_q   <= newspaper_d;
      change_req_q  <= change_req_d;
      coin_reject_q <= coin_reject_d;
      fault_q       <= fault_d;
    end
  end

  assign ready_a_o     = gnt_a;
  assign ready_b_o     = gnt_b;
  assign newspaper_o   = newspaper_q;
  assign change_req_o  = change_req_q;
  assign credit_o      = credit_q;
  assign coin_reject_o = coin_reject_q;
  assign fault_o       = fault_q;

endmodule

// File: tb/tb_vend_coin_scheduler.sv
// Scenario bench for vend_coin_scheduler; expected credits are queued as coins are driven.
module tb_vend_coin_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] coin_a, coin_b;
  logic       disp_ack, chg_ack;
  logic       ready_a, ready_b, newspaper, change_req, coin_reject, fault;
  logic [4:0] credit;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  vend_coin_scheduler #(.DISP_TIMEOUT(16), .PRICE(15)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .coin_a_i       (coin_a),
    .coin_b_i       (coin_b),
    .ready_a_o      (ready_a),
    .ready_b_o      (ready_b),
    .dispense_ack_i (disp_ack),
    .change_ack_i   (chg_ack),
    .newspaper_o    (newspaper),
    .change_req_o   (change_req),
    .credit_o       (credit),
    .coin_reject_o  (coin_reject),
    .fault_o        (fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; coin_a = 2'b00; coin_b = 2'b00; disp_ack = 1'b0; chg_ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; coin_a = 2'b00; coin_b = 2'b00; disp_ack = 1'b0; chg_ack = 1'b0;
    tick();
    n_cmp++;
    if ({newspaper, change_req, coin_reject, fault, credit, ready_a, ready_b} !== 11'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got np=%b cr=%b rej=%b flt=%b credit=%0d, need all 0",
               newspaper, change_req, coin_reject, fault, credit);
    end
    do_reset();
    $display("reset: credit=%0d fault=%b", credit, fault);
  endtask

  // Three nickels on slot A, dispense, no change.
  task automatic test_three_nickels();
    int e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      coin_a = 2'b01;
      #1;
      n_cmp++;
      if ({ready_a, ready_b} !== 2'b10) begin
        n_bad++; $display("FAIL nickel_ready[%0d]: got a=%b b=%b, need a=1 b=0", i, ready_a, ready_b);
      end
      exp_q.push_back(5 * (i + 1));
      tick();
      coin_a = 2'b00;
      e = exp_q.pop_front();
      n_cmp++;
      if (credit !== 5'(e)) begin
        n_bad++; $display("FAIL nickel_credit[%0d]: got %0d, need %0d", i, credit, e);
      end
      $display("nickel %0d: credit=%0d newspaper=%b", i, credit, newspaper);
    end
    n_cmp++;
    if (newspaper !== 1'b1) begin
      n_bad++; $display("FAIL nickel_newspaper: got %b, need 1", newspaper);
    end
    coin_a = 2'b01;
    #1;
    n_cmp++;
    if (ready_a !== 1'b0) begin
      n_bad++; $display("FAIL dispense_no_ready: got ready_a=%b, need 0", ready_a);
    end
    coin_a = 2'b00;
    disp_ack = 1'b1;
    tick();
    disp_ack = 1'b0;
    n_cmp++;
    if ({credit, newspaper, change_req} !== 7'd0) begin
      n_bad++; $display("FAIL nickel_after_ack: got credit=%0d np=%b cr=%b, need 0 0 0",
                        credit, newspaper, change_req);
    end
    $display("nickel ack: credit=%0d newspaper=%b change_req=%b", credit, newspaper, change_req);
  endtask

  // Dime on A then dime on B: dispense at 20, return one nickel.
  task automatic test_dime_change();
    int e;
    do_reset();
    coin_a = 2'b10; exp_q.push_back(10);
    tick();
    coin_a = 2'b00;
    e = exp_q.pop_front();
    n_cmp++;
    if (credit !== 5'(e)) begin
      n_bad++; $display("FAIL dime_a_credit: got %0d, need %0d", credit, e);
    end
    coin_b = 2'b10; exp_q.push_back(20);
    tick();
    coin_b = 2'b00;
    e = exp_q.pop_front();
    n_cmp++;
    if (credit !== 5'(e) || newspaper !== 1'b1) begin
      n_bad++; $display("FAIL dime_b_dispense: got credit=%0d np=%b, need %0d 1", credit, newspaper, e);
    end
    chg_ack = 1'b1;
    tick();
    chg_ack = 1'b0;
    n_cmp++;
    if (newspaper !== 1'b1 || change_req !== 1'b0) begin
      n_bad++; $display("FAIL stray_change_ack: got np=%b cr=%b, need 1 0", newspaper, change_req);
    end
    disp_ack = 1'b1;
    tick();
    disp_ack = 1'b1;
    n_cmp++;
    if (credit !== 5'd5 || change_req !== 1'b1 || newspaper !== 1'b0) begin
      n_bad++; $display("FAIL dime_change_req: got credit=%0d cr=%b np=%b, need 5 1 0",
                        credit, change_req, newspaper);
    end
    tick();
    disp_ack = 1'b0;
    n_cmp++;
    if (credit !== 5'd5 || change_req !== 1'b1) begin
      n_bad++; $display("FAIL stray_dispense_ack: got credit=%0d cr=%b, need 5 1", credit, change_req);
    end
    chg_ack = 1'b1;
    tick();
    chg_ack = 1'b0;
    n_cmp++;
    if (credit !== 5'd0 || change_req !== 1'b0) begin
      n_bad++; $display("FAIL change_done: got credit=%0d cr=%b, need 0 0", credit, change_req);
    end
    $display("dime change: credit=%0d change_req=%b", credit, change_req);
  endtask

  // Simultaneous nickel on A and dime on B; A wins first tie, B then granted.
  task automatic test_tie();
    int e;
    do_reset();
    coin_a = 2'b01; coin_b = 2'b10;
    #1;
    n_cmp++;
    if ({ready_a, ready_b} !== 2'b10) begin
      n_bad++; $display("FAIL tie_first: got a=%b b=%b, need a=1 b=0", ready_a, ready_b);
    end
    exp_q.push_back(5);
    tick();
    coin_a = 2'b00;
    e = exp_q.pop_front();
    n_cmp++;
    if (credit !== 5'(e)) begin
      n_bad++; $display("FAIL tie_credit_a: got %0d, need %0d", credit, e);
    end
    n_cmp++;
    if ({ready_a, ready_b} !== 2'b01) begin
      n_bad++; $display("FAIL tie_second: got a=%b b=%b, need a=0 b=1", ready_a, ready_b);
    end
    exp_q.push_back(15);
    tick();
    coin_b = 2'b00;
    e = exp_q.pop_front();
    n_cmp++;
    if (credit !== 5'(e) || newspaper !== 1'b1) begin
      n_bad++; $display("FAIL tie_dispense: got credit=%0d np=%b, need %0d 1", credit, newspaper, e);
    end
    $display("tie: credit=%0d newspaper=%b", credit, newspaper);
  endtask

  // Both slots hold nickels every cycle: grants alternate A, B, A.
  task automatic test_back_to_back();
    int e;
    logic [1:0] want;
    do_reset();
    coin_a = 2'b01; coin_b = 2'b01;
    for (int i = 0; i < 3; i++) begin
      #1;
      want = (i % 2 == 0) ? 2'b10 : 2'b01;
      n_cmp++;
      if ({ready_a, ready_b} !== want) begin
        n_bad++; $display("FAIL b2b_grant[%0d]: got %b, need %b", i, {ready_a, ready_b}, want);
      end
      exp_q.push_back(5 * (i + 1));
      tick();
      e = exp_q.pop_front();
      n_cmp++;
      if (credit !== 5'(e)) begin
        n_bad++; $display("FAIL b2b_credit[%0d]: got %0d, need %0d", i, credit, e);
      end
      $display("b2b %0d: grant=%b credit=%0d", i, want, credit);
    end
    coin_a = 2'b00; coin_b = 2'b00;
  endtask

  // Invalid code on B: accepted, reject pulse next cycle, credit unchanged.
  task automatic test_reject();
    do_reset();
    coin_a = 2'b01;
    tick();
    coin_a = 2'b00;
    coin_b = 2'b11;
    #1;
    n_cmp++;
    if (ready_b !== 1'b1) begin
      n_bad++; $display("FAIL reject_ready: got ready_b=%b, need 1", ready_b);
    end
    n_cmp++;
    if (coin_reject !== 1'b0) begin
      n_bad++; $display("FAIL reject_early: got coin_reject=%b, need 0", coin_reject);
    end
    tick();
    coin_b = 2'b00;
    n_cmp++;
    if (coin_reject !== 1'b1 || credit !== 5'd5) begin
      n_bad++; $display("FAIL reject_pulse: got rej=%b credit=%0d, need 1 5", coin_reject, credit);
    end
    tick();
    n_cmp++;
    if (coin_reject !== 1'b0) begin
      n_bad++; $display("FAIL reject_width: got coin_reject=%b, need 0", coin_reject);
    end
    $display("reject: credit=%0d", credit);
  endtask

  // No ack: fault after 16 cycles in DISPENSE, sticky, cleared by async reset.
  task automatic test_timeout();
    do_reset();
    coin_a = 2'b01;
    tick(); tick(); tick();
    coin_a = 2'b00;
    for (int k = 1; k <= 15; k++) tick();
    n_cmp++;
    if (fault !== 1'b0 || newspaper !== 1'b1) begin
      n_bad++; $display("FAIL timeout_early: got fault=%b np=%b, need 0 1", fault, newspaper);
    end
    tick();
    n_cmp++;
    if (fault !== 1'b1 || newspaper !== 1'b0 || credit !== 5'd15) begin
      n_bad++; $display("FAIL timeout_fault: got fault=%b np=%b credit=%0d, need 1 0 15",
                        fault, newspaper, credit);
    end
    disp_ack = 1'b1;
    tick();
    disp_ack = 1'b0;
    n_cmp++;
    if (fault !== 1'b1 || credit !== 5'd15) begin
      n_bad++; $display("FAIL fault_sticky: got fault=%b credit=%0d, need 1 15", fault, credit);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({fault, newspaper, change_req, coin_reject, credit} !== 9'd0) begin
      n_bad++; $display("FAIL fault_reset: got fault=%b np=%b credit=%0d, need all 0",
                        fault, newspaper, credit);
    end
    tick();
    rst = 1'b0;
    $display("timeout: fault cleared=%b", ~fault);
  endtask

  // Ack on the expiry cycle beats the fault; then reset mid-DISPENSE.
  task automatic test_ack_at_expiry();
    do_reset();
    coin_a = 2'b01;
    tick(); tick(); tick();
    coin_a = 2'b00;
    for (int k = 1; k <= 15; k++) tick();
    disp_ack = 1'b1;
    tick();
    disp_ack = 1'b0;
    n_cmp++;
    if (fault !== 1'b0 || newspaper !== 1'b0 || credit !== 5'd0) begin
      n_bad++; $display("FAIL ack_expiry: got fault=%b np=%b credit=%0d, need 0 0 0",
                        fault, newspaper, credit);
    end
    coin_a = 2'b10;
    tick();
    tick();
    coin_a = 2'b00;
    tick();
    n_cmp++;
    if (newspaper !== 1'b1 || credit !== 5'd20) begin
      n_bad++; $display("FAIL mid_dispense_setup: got np=%b credit=%0d, need 1 20", newspaper, credit);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (newspaper !== 1'b0 || credit !== 5'd0) begin
      n_bad++; $display("FAIL async_reset: got np=%b credit=%0d, need 0 0", newspaper, credit);
    end
    tick();
    rst = 1'b0;
    $display("ack at expiry: fault=%b newspaper=%b", fault, newspaper);
  endtask

  initial begin
    test_reset();
    test_three_nickels();
    test_dime_change();
    test_tie();
    test_back_to_back();
    test_reject();
    test_timeout();
    test_ack_at_expiry();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vend_coin_scheduler.md
VEND_COIN_SCHEDULER -- requirements
Module: vend_coin_scheduler

Interface
REQ-001 Parameter DISP_TIMEOUT, default 16; cycles allowed for dispense_ack or change_ack before fault.
REQ-002 Parameter PRICE, default 15; newspaper price in cents.
REQ-003 clock  input  1  single system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 coin_a  input  2  slot A coin code: 00 none, 01 nickel (5), 10 dime (10), 11 invalid.
REQ-006 coin_b  input  2  slot B coin code, same encoding as coin_a.
REQ-007 ready_a  output  1  slot A coin accepted on this rising edge.
REQ-008 ready_b  output  1  slot B coin accepted on this rising edge.
REQ-009 dispense_ack  input  1  dispenser has released one newspaper.
REQ-010 change_ack  input  1  change mechanism has returned one nickel.
REQ-011 newspaper  output  1  dispense request, registered.
REQ-012 change_req  output  1  return-one-nickel request, registered.
REQ-013 credit  output  5  current accumulated credit in cents.
REQ-014 coin_reject  output  1  one-cycle pulse after an accepted 11 code.
REQ-015 fault  output  1  sticky timeout indication.

Function
REQ-016 States: IDLE (credit 0), C5, C10, DISPENSE, CHANGE, FAULT.
REQ-017 Slot X is valid when coin_X != 00; a coin transfers on a rising edge where it is valid and ready_X is 1.
REQ-018 ready_a/ready_b are combinational and one-hot-or-zero; both are 0 in DISPENSE, CHANGE and FAULT.
REQ-019 In IDLE/C5/C10 with one slot valid, that slot is granted.
REQ-020 With both slots valid, grant round-robin: the slot not granted last wins; the losing slot holds its code until granted.
REQ-021 An accepted nickel adds 5 and an accepted dime adds 10 to credit on the same edge; at most one coin is accepted per cycle.
REQ-022 An accepted 11 leaves credit unchanged and pulses coin_reject for the next cycle.
REQ-023 When credit becomes >= PRICE, the state becomes DISPENSE on that edge and newspaper is 1 from that edge on.
REQ-024 In DISPENSE, newspaper stays 1 until an edge with dispense_ack=1; on that edge credit -= PRICE and newspaper drops.
REQ-025 After dispense_ack: if the remaining credit is 5 (entry at 20), go to CHANGE; else go to IDLE.
REQ-026 In CHANGE, change_req stays 1 until an edge with change_ack=1; then credit=0 and the state becomes IDLE.
REQ-027 A 5-bit timer clears on entry to DISPENSE/CHANGE and increments each cycle there.
REQ-028 If the timer reaches DISP_TIMEOUT-1 without an ack, go to FAULT: fault=1, newspaper=0, change_req=0, and credit is held.
REQ-029 Ack in the same cycle as timer expiry: the ack wins and no fault is raised.
REQ-030 FAULT exits only by reset.
REQ-031 An ack outside its matching state is ignored.

Reset
REQ-032 Reset drives state IDLE, credit 0, and newspaper, change_req, coin_reject and fault to 0.
REQ-033 Reset clears the timer and the round-robin pointer to "B last" (A wins first tie), without waiting for a clock edge.
REQ-034 Reset asserted mid-DISPENSE drops newspaper immediately and discards credit.

Structure
REQ-035 vend_pkg shall hold the coin codes (NONE, NICKEL, DIME, INVALID), the state enumeration, and the nickel/dime values.
REQ-036 A single sub-module, vend_rr_arb, shall implement the two-requester round-robin grant and its pointer.

Verification
REQ-037 Three nickels on A in consecutive cycles: credit 5, 10, 15, then newspaper=1; ack gives credit 0, IDLE, no change_req.
REQ-038 Dime on A then dime on B: newspaper with credit 20; ack gives credit 5 and change_req=1; change_ack gives credit 0.
REQ-039 Nickel on A and dime on B in the same cycle, both held: A granted first (credit 5), then B (credit 15), then dispense.
REQ-040 Code 11 on B: ready_b=1, coin_reject pulse one cycle later, credit unchanged.
REQ-041 Reach DISPENSE with no ack: fault=1 after DISP_TIMEOUT cycles, newspaper=0, credit 15; reset clears all outputs to 0.
REQ-042 Ack on the exact expiry cycle: no fault; then reset asserted mid-DISPENSE drops newspaper asynchronously.
